// File: rtl/lsu_handshake.sv
// Load/store unit between the execute stage and the data-memory port.
// Multi-cycle request/valid handshake with byte/half/word/double lanes,
// misalignment detection and a timeout on unresponsive memory.
module lsu_handshake #(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    input  logic                   op_we,
    input  logic [1:0]             op_size,
    input  logic                   op_unsigned,
    input  logic [DataWidth-1:0]   op_addr,
    input  logic [DataWidth-1:0]   op_wdata,
    output logic                   stall,
    output logic                   done,
    output logic [DataWidth-1:0]   rdata,
    output logic                   misaligned,
    output logic                   access_fault,
    output logic                   mem_request,
    output logic                   mem_we_re,
    output logic [DataWidth/8-1:0] mem_mask,
    output logic [DataWidth-1:0]   mem_addr,
    output logic [DataWidth-1:0]   mem_wdata,
    input  logic                   mem_valid,
    input  logic [DataWidth-1:0]   mem_rdata
);
    localparam int NB   = DataWidth / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [DataWidth-1:0] ALIGN_MASK = ~(DataWidth'(NB - 1));
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TimeoutCycles);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Byte offset inside the data word, widened to 3 bits for both datapaths.
    function automatic logic [2:0] byte_off(input logic [DataWidth-1:0] addr);
        return 3'(addr[OFFW-1:0]);
    endfunction

    // Misaligned for its size, or a double access on a 32-bit datapath.
    function automatic logic op_is_bad(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            2'b11:   bad = (DataWidth == 32) ? 1'b1 : |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables: 2^size contiguous lanes starting at the byte offset.
    function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [NB-1:0] m;
        m = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(off)) && (i < int'(off) + (1 << size))) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Right-justify the addressed lanes and sign/zero extend; full-width loads pass through.
    function automatic logic [DataWidth-1:0] format_load(input logic [DataWidth-1:0] raw,
                                                         input logic [1:0] size,
                                                         input logic [2:0] off,
                                                         input logic uns);
        logic [DataWidth-1:0] sh;
        logic [DataWidth-1:0] low_mask;
        logic [DataWidth-1:0] res;
        int nbits;
        int sidx;
        sh    = raw >> {off, 3'b000};
        nbits = 8 * (1 << size);
        sidx  = (nbits < DataWidth) ? (nbits - 1) : (DataWidth - 1);
        for (int i = 0; i < DataWidth; i++) begin
            low_mask[i] = (i < nbits) ? 1'b1 : 1'b0;
        end
        if (!uns && (nbits < DataWidth) && sh[sidx]) begin
            res = sh | ~low_mask;
        end else begin
            res = sh & low_mask;
        end
        return res;
    endfunction

    state_t                 state_r, state_n;
    logic [15:0]            cnt_r, cnt_n;
    logic                   bad_s;
    logic                   timeout_s;
    logic [2:0]             op_off_s;
    logic                   we_r;
    logic [1:0]             size_r;
    logic                   uns_r;
    logic [2:0]             off_r;
    logic [DataWidth-1:0]   addr_r;
    logic [NB-1:0]          mask_r;
    logic [DataWidth-1:0]   wdata_r;
    logic [DataWidth-1:0]   rdata_r;
    logic                   mis_r;
    logic                   fault_r;

    assign op_off_s = byte_off(op_addr);
    assign bad_s    = op_is_bad(op_size, op_off_s);

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state logic: acceptance, handshake progress and timeout detection.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n = 16'd0;
                if (op_valid) begin
                    state_n = bad_s ? ST_RESP : ST_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_valid) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    state_n = ST_RESP;
                end else if ((cnt_r + 16'd1) == TIMEOUT_LIMIT) begin
                    state_n   = ST_RESP;
                    timeout_s = 1'b1;
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Latch op fields at acceptance, capture the load result or the fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            off_r   <= 3'd0;
            addr_r  <= {DataWidth{1'b0}};
            mask_r  <= {NB{1'b0}};
            wdata_r <= {DataWidth{1'b0}};
            rdata_r <= {DataWidth{1'b0}};
            mis_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_valid && bad_s) begin
                        mis_r   <= 1'b1;
                        fault_r <= 1'b0;
                        rdata_r <= {DataWidth{1'b0}};
                    end else if (op_valid) begin
                        we_r    <= op_we;
                        size_r  <= op_size;
                        uns_r   <= op_unsigned;
                        off_r   <= op_off_s;
                        addr_r  <= op_addr & ALIGN_MASK;
                        mask_r  <= lane_mask(op_size, op_off_s);
                        wdata_r <= op_wdata << {op_off_s, 3'b000};
                        mis_r   <= 1'b0;
                        fault_r <= 1'b0;
                    end else begin
                        mis_r   <= 1'b0;
                        fault_r <= 1'b0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (mem_valid) begin
                        rdata_r <= we_r ? {DataWidth{1'b0}}
                                        : format_load(mem_rdata, size_r, off_r, uns_r);
                    end else if (timeout_s) begin
                        fault_r <= 1'b1;
                        rdata_r <= {DataWidth{1'b0}};
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                ST_RESP: begin
                    rdata_r <= {DataWidth{1'b0}};
                    mis_r   <= 1'b0;
                    fault_r <= 1'b0;
                end
                default: begin
                    rdata_r <= {DataWidth{1'b0}};
                    mis_r   <= 1'b0;
                    fault_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_request  = (state_r == ST_REQ) || (state_r == ST_WAIT);
    assign stall        = ((state_r == ST_IDLE) && op_valid) || mem_request;
    assign done         = (state_r == ST_RESP);
    assign rdata        = rdata_r;
    assign misaligned   = done && mis_r;
    assign access_fault = done && fault_r;
    assign mem_we_re    = we_r;
    assign mem_mask     = mask_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake: 32-bit instance with a short timeout and
// a 64-bit instance, expected values computed by hand.
module tb_lsu_handshake;
    logic        clk;
    logic        rst;

    logic        op_valid, op_we, op_unsigned, mem_valid;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata, mem_rdata;
    logic        stall, done, misaligned, access_fault, mem_request, mem_we_re;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;

    logic        w_op_valid, w_op_we, w_op_unsigned, w_mem_valid;
    logic [1:0]  w_op_size;
    logic [63:0] w_op_addr, w_op_wdata, w_mem_rdata;
    logic        w_stall, w_done, w_misaligned, w_access_fault, w_mem_request, w_mem_we_re;
    logic [63:0] w_rdata, w_mem_addr, w_mem_wdata;
    logic [7:0]  w_mem_mask;

    int n_vec = 0;
    int n_err = 0;

    lsu_handshake #(.DataWidth(32), .TimeoutCycles(4)) dut32 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_we(op_we), .op_size(op_size),
        .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned),
        .access_fault(access_fault), .mem_request(mem_request), .mem_we_re(mem_we_re),
        .mem_mask(mem_mask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    lsu_handshake #(.DataWidth(64), .TimeoutCycles(8)) dut64 (
        .clk(clk), .rst(rst), .op_valid(w_op_valid), .op_we(w_op_we), .op_size(w_op_size),
        .op_unsigned(w_op_unsigned), .op_addr(w_op_addr), .op_wdata(w_op_wdata),
        .stall(w_stall), .done(w_done), .rdata(w_rdata), .misaligned(w_misaligned),
        .access_fault(w_access_fault), .mem_request(w_mem_request), .mem_we_re(w_mem_we_re),
        .mem_mask(w_mem_mask), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_valid(w_mem_valid), .mem_rdata(w_mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        op_valid = 1'b0; op_we = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
        op_addr = 32'h0; op_wdata = 32'h0; mem_valid = 1'b0; mem_rdata = 32'h0;
        w_op_valid = 1'b0; w_op_we = 1'b0; w_op_size = 2'b00; w_op_unsigned = 1'b0;
        w_op_addr = 64'h0; w_op_wdata = 64'h0; w_mem_valid = 1'b0; w_mem_rdata = 64'h0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check_vec("rst_done",  64'(done), 64'd0);
        check_vec("rst_req",   64'(mem_request), 64'd0);
        check_vec("rst_stall", 64'(stall), 64'd0);
        check_vec("rst_rdata", 64'(rdata), 64'd0);
        check_vec("rst_mask",  64'(mem_mask), 64'd0);
        check_vec("rst_addr",  64'(mem_addr), 64'd0);

        // Signed byte load at 0x103, memory answers in the first request cycle.
        op_valid = 1'b1; op_we = 1'b0; op_size = 2'b00; op_unsigned = 1'b0; op_addr = 32'h0000_0103;
        #1;
        check_vec("lb_stall_T", 64'(stall), 64'd1);
        cycle();
        check_vec("lb_req",  64'(mem_request), 64'd1);
        check_vec("lb_mask", 64'(mem_mask), 64'h8);
        check_vec("lb_addr", 64'(mem_addr), 64'h100);
        check_vec("lb_we",   64'(mem_we_re), 64'd0);
        check_vec("lb_done_early", 64'(done), 64'd0);
        mem_rdata = 32'h80FF_FF00; mem_valid = 1'b1;
        cycle();
        check_vec("lb_done",  64'(done), 64'd1);
        check_vec("lb_rdata", 64'(rdata), 64'hFFFF_FF80);
        check_vec("lb_mis",   64'(misaligned), 64'd0);
        check_vec("lb_stall_resp", 64'(stall), 64'd0);
        check_vec("lb_req_resp", 64'(mem_request), 64'd0);
        mem_valid = 1'b0; op_valid = 1'b0;
        cycle();
        check_vec("lb_done_pulse", 64'(done), 64'd0);

        // Half store at 0x202, memory acks in the fourth request cycle.
        op_valid = 1'b1; op_we = 1'b1; op_size = 2'b01; op_addr = 32'h0000_0202; op_wdata = 32'h0000_BEEF;
        cycle();
        check_vec("sh_mask",  64'(mem_mask), 64'hC);
        check_vec("sh_wdata", 64'(mem_wdata), 64'hBEEF_0000);
        check_vec("sh_we",    64'(mem_we_re), 64'd1);
        check_vec("sh_addr",  64'(mem_addr), 64'h200);
        for (int i = 0; i < 4; i++) begin
            check_vec($sformatf("sh_req%0d", i), 64'(mem_request), 64'd1);
            check_vec($sformatf("sh_stall%0d", i), 64'(stall), 64'd1);
            check_vec($sformatf("sh_nodone%0d", i), 64'(done), 64'd0);
            if (i == 3) mem_valid = 1'b1;
            cycle();
        end
        check_vec("sh_done",  64'(done), 64'd1);
        check_vec("sh_fault", 64'(access_fault), 64'd0);
        mem_valid = 1'b0; op_valid = 1'b0;
        cycle();

        // Misaligned word load: done at T+1, never a request.
        op_valid = 1'b1; op_we = 1'b0; op_size = 2'b10; op_addr = 32'h0000_0101;
        #1;
        check_vec("mis_req_T", 64'(mem_request), 64'd0);
        cycle();
        check_vec("mis_done",  64'(done), 64'd1);
        check_vec("mis_flag",  64'(misaligned), 64'd1);
        check_vec("mis_req",   64'(mem_request), 64'd0);
        check_vec("mis_rdata", 64'(rdata), 64'd0);
        op_valid = 1'b0;
        cycle();
        check_vec("mis_flag_off", 64'(misaligned), 64'd0);

        // Timeout: REQ plus four WAIT cycles, then the fault pulse.
        op_valid = 1'b1; op_size = 2'b10; op_addr = 32'h0000_0300;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_vec($sformatf("to_req%0d", i), 64'(mem_request), 64'd1);
            check_vec($sformatf("to_nodone%0d", i), 64'(done), 64'd0);
            cycle();
        end
        check_vec("to_done",  64'(done), 64'd1);
        check_vec("to_fault", 64'(access_fault), 64'd1);
        check_vec("to_req_drop", 64'(mem_request), 64'd0);
        check_vec("to_rdata", 64'(rdata), 64'd0);
        op_valid = 1'b0;
        cycle();
        check_vec("to_fault_off", 64'(access_fault), 64'd0);

        // Unsigned half load after the fault completes normally.
        op_valid = 1'b1; op_size = 2'b01; op_unsigned = 1'b1; op_addr = 32'h0000_0302;
        cycle();
        check_vec("lhu_mask", 64'(mem_mask), 64'hC);
        mem_rdata = 32'h8001_0000; mem_valid = 1'b1;
        cycle();
        check_vec("lhu_done",  64'(done), 64'd1);
        check_vec("lhu_rdata", 64'(rdata), 64'h0000_8001);
        check_vec("lhu_fault", 64'(access_fault), 64'd0);
        mem_valid = 1'b0; op_valid = 1'b0; op_unsigned = 1'b0;
        cycle();

        // 64-bit datapath: unsigned word at 0x1004, then signed word at 0x1000.
        w_op_valid = 1'b1; w_op_size = 2'b10; w_op_unsigned = 1'b1; w_op_addr = 64'h1004;
        cycle();
        check_vec("w_lwu_mask", 64'(w_mem_mask), 64'hF0);
        check_vec("w_lwu_addr", w_mem_addr, 64'h1000);
        check_vec("w_lwu_req",  64'(w_mem_request), 64'd1);
        w_mem_rdata = 64'h8765_4321_0000_0000; w_mem_valid = 1'b1;
        cycle();
        check_vec("w_lwu_done",  64'(w_done), 64'd1);
        check_vec("w_lwu_rdata", w_rdata, 64'h0000_0000_8765_4321);
        w_mem_valid = 1'b0; w_op_valid = 1'b0;
        cycle();
        w_op_valid = 1'b1; w_op_unsigned = 1'b0; w_op_addr = 64'h1000;
        cycle();
        check_vec("w_lw_mask", 64'(w_mem_mask), 64'h0F);
        w_mem_rdata = 64'h0000_0000_8000_0000; w_mem_valid = 1'b1;
        cycle();
        check_vec("w_lw_rdata", w_rdata, 64'hFFFF_FFFF_8000_0000);
        w_mem_valid = 1'b0; w_op_valid = 1'b0;
        cycle();

        // Reset during WAIT aborts the op; a late mem_valid is ignored.
        op_valid = 1'b1; op_size = 2'b10; op_addr = 32'h0000_0400;
        cycle();
        cycle();
        check_vec("rw_req_wait", 64'(mem_request), 64'd1);
        rst = 1'b1; op_valid = 1'b0;
        cycle();
        check_vec("rw_req",   64'(mem_request), 64'd0);
        check_vec("rw_stall", 64'(stall), 64'd0);
        check_vec("rw_done",  64'(done), 64'd0);
        rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cycle();
        check_vec("rw_spur_done", 64'(done), 64'd0);
        check_vec("rw_spur_req",  64'(mem_request), 64'd0);
        mem_valid = 1'b0;
        cycle();
        check_vec("rw_spur_rdata", 64'(rdata), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
